// File: rtl/mul_acc_seq.sv
// mul_acc_seq: multiply sequencing and accumulate stage.
// Sits after the multiply unit. It strobes the unit, selects which product half
// the unit drives on B, and adds the C-bus operand to that half. The result is
// 32 or 64 bits, with N/Z flags for writeback.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   START     in   request a sequence (sampled in IDLE and DONE only)
//   LONG      in   1 = 64-bit result, latched at accepted START
//   ACC       in   1 = add C_In operand, latched at accepted START
//   B_In      in   product half from the multiply unit
//   C_In      in   accumulate operand half (low word in LO, high word in HI)
//   LD_MUL    out  multiply unit load strobe (MULT state)
//   MUL_HiLo  out  product half select, 1 = high (HI state)
//   BUSY      out  sequence in progress (MULT, LO, HI)
//   DONE      out  one-cycle result-valid pulse
//   RES_LO    out  result [31:0]
//   RES_HI    out  result [63:32], 0 for short results
//   N         out  result sign over the active width
//   Z         out  result is zero over the active width
module mul_acc_seq (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        LONG,
    input  logic        ACC,
    input  logic [31:0] B_In,
    input  logic [31:0] C_In,
    output logic        LD_MUL,
    output logic        MUL_HiLo,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RES_LO,
    output logic [31:0] RES_HI,
    output logic        N,
    output logic        Z
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MULT = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        long_q, long_d;
    logic        acc_q, acc_d;
    logic        carry_q, carry_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic        n_q, n_d;
    logic        z_q, z_d;

    logic        accept;
    logic [31:0] opnd;
    logic [32:0] sum_lo;
    logic [31:0] sum_hi;

    // START only counts when the sequencer is between results.
    assign accept = START && (state_q == S_IDLE || state_q == S_DONE);
    assign opnd   = acc_q ? C_In : 32'd0;
    assign sum_lo = {1'b0, B_In} + {1'b0, opnd};
    assign sum_hi = B_In + opnd + {31'd0, carry_q};

    always_comb begin
        state_d  = state_q;
        long_d   = accept ? LONG : long_q;
        acc_d    = accept ? ACC : acc_q;
        carry_d  = carry_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        n_d      = n_q;
        z_d      = z_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_MULT : S_IDLE;
            S_MULT:  state_d = S_LO;
            S_LO: begin
                state_d  = long_q ? S_HI : S_DONE;
                res_lo_d = sum_lo[31:0];
                carry_d  = sum_lo[32];
                // A short result finalises its flags here; a long one waits for HI.
                if (!long_q) begin
                    res_hi_d = 32'd0;
                    n_d      = sum_lo[31];
                    z_d      = (sum_lo[31:0] == 32'd0);
                end
            end
            S_HI: begin
                state_d  = S_DONE;
                res_hi_d = sum_hi;
                n_d      = sum_hi[31];
                z_d      = (res_lo_q == 32'd0) && (sum_hi == 32'd0);
            end
            S_DONE:  state_d = accept ? S_MULT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            long_q   <= 1'b0;
            acc_q    <= 1'b0;
            carry_q  <= 1'b0;
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            long_q   <= long_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

    assign LD_MUL   = (state_q == S_MULT);
    assign MUL_HiLo = (state_q == S_HI);
    assign BUSY     = (state_q == S_MULT) || (state_q == S_LO) || (state_q == S_HI);
    assign DONE     = (state_q == S_DONE);
    assign RES_LO   = res_lo_q;
    assign RES_HI   = res_hi_q;
    assign N        = n_q;
    assign Z        = z_q;
endmodule

// File: tb/tb_mul_acc_seq.sv
// tb_mul_acc_seq: directed self-checking bench for mul_acc_seq.
module tb_mul_acc_seq;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        LONG = 1'b0;
    logic        ACC = 1'b0;
    logic [31:0] B_In = 32'd0;
    logic [31:0] C_In = 32'd0;
    logic        LD_MUL, MUL_HiLo, BUSY, DONE, N, Z;
    logic [31:0] RES_LO, RES_HI;
    int          checks = 0;
    int          errors = 0;

    mul_acc_seq dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LONG(LONG), .ACC(ACC),
        .B_In(B_In), .C_In(C_In), .LD_MUL(LD_MUL), .MUL_HiLo(MUL_HiLo),
        .BUSY(BUSY), .DONE(DONE), .RES_LO(RES_LO), .RES_HI(RES_HI), .N(N), .Z(Z)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run(input logic lg, input logic ac,
                       input logic [31:0] bl, input logic [31:0] cl,
                       input logic [31:0] bh, input logic [31:0] ch,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic en, input logic ez);
        START = 1'b1; LONG = lg; ACC = ac; B_In = bl; C_In = cl;
        step;
        chk("mult_outs", {LD_MUL, MUL_HiLo, BUSY, DONE}, 4'b1010);
        START = 1'b0;
        step;
        chk("lo_outs", {LD_MUL, MUL_HiLo, BUSY, DONE}, 4'b0010);
        if (lg) begin
            step;
            B_In = bh; C_In = ch;
            chk("hi_outs", {LD_MUL, MUL_HiLo, BUSY, DONE}, 4'b0110);
        end
        step;
        chk("done_outs", {LD_MUL, MUL_HiLo, BUSY, DONE}, 4'b0001);
        chk("res", {RES_HI, RES_LO}, {ehi, elo});
        chk("nz", {N, Z}, {en, ez});
        step;
        chk("idle_outs", {LD_MUL, MUL_HiLo, BUSY, DONE}, 4'b0000);
        chk("res_hold", {RES_HI, RES_LO}, {ehi, elo});
        chk("nz_hold", {N, Z}, {en, ez});
    endtask

    initial begin
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_outs", {LD_MUL, MUL_HiLo, BUSY, DONE, N, Z}, 6'd0);
        chk("rst_res", {RES_HI, RES_LO}, 64'd0);
        RST_N = 1'b1;
        step;
        chk("idle_after_rst", {LD_MUL, MUL_HiLo, BUSY, DONE}, 4'b0000);

        // short MLA: 6 + 0xFFFFFFFA wraps to zero
        run(1'b0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFA, 32'h0, 32'h0,
            32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
        // long accumulate, carry from low half into high half
        run(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFFF,
            32'h0000_0000, 32'h8000_0001, 1'b1, 1'b0);
        // ACC=0 ignores the C bus
        run(1'b1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF,
            32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0);
        // short result after a long one clears RES_HI; N from bit 31
        run(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h0, 32'h0,
            32'h8000_0001, 32'h0000_0000, 1'b1, 1'b0);

        // START held high, LONG alternating: short, long, short, long
        START = 1'b1; LONG = 1'b0; ACC = 1'b0; B_In = 32'd1; C_In = 32'd0;
        for (int k = 0; k < 14; k++) begin
            step;
            chk($sformatf("b2b_ld%0d", k), LD_MUL, (k == 0 || k == 3 || k == 7 || k == 10));
            chk($sformatf("b2b_done%0d", k), DONE, (k == 2 || k == 6 || k == 9 || k == 13));
            if (DONE) LONG = ~LONG;
        end
        START = 1'b0;
        step;
        chk("b2b_res", {RES_HI, RES_LO}, {32'd1, 32'd1});

        // asynchronous reset during HI of a long sequence
        START = 1'b1; LONG = 1'b1; ACC = 1'b1; B_In = 32'd5; C_In = 32'd5;
        step;
        START = 1'b0;
        step;
        step;
        chk("pre_rst_hi", {MUL_HiLo, BUSY, RES_LO}, {2'b11, 32'd10});
        #2 RST_N = 1'b0;
        #1;
        chk("async_outs", {LD_MUL, MUL_HiLo, BUSY, DONE, N, Z}, 6'd0);
        chk("async_res", {RES_HI, RES_LO}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0020, 32'h0, 32'h0,
            32'h0000_0030, 32'h0000_0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_acc_seq.md
# mul_acc_seq

Sequencing and accumulate stage that sits directly downstream of the multiply unit in the multiply / multiply-long datapath. It pulses the multiply unit's load strobe and steers its Hi/Lo output select. It captures the 32-bit product halves from the B bus and adds the accumulate operand from the C bus (Rn for MLA, RdHi:RdLo for UMLAL/SMLAL). It returns a 32- or 64-bit result plus N/Z flags for writeback.

## Interface
- No parameters; all widths are fixed at 32/64 bits.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- START  in  1  request a new multiply sequence; sampled in IDLE and DONE only.
- LONG  in  1  1 = 64-bit result (multiply-long family); 0 = 32-bit result; latched at accepted START.
- ACC  in  1  1 = add C_In operand (MLA/xMLAL); 0 = operand treated as zero; latched at accepted START.
- B_In  in  32  product half from the multiply unit output on the B bus.
- C_In  in  32  accumulate operand half on the C bus: low word during LO, high word during HI.
- LD_MUL  out  1  load strobe to the multiply unit.
- MUL_HiLo  out  1  product half select to the multiply unit: 0 = low, 1 = high.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle result-valid pulse.
- RES_LO  out  32  result bits [31:0].
- RES_HI  out  32  result bits [63:32]; 0 when LONG=0.
- N  out  1  result sign bit: bit 63 if long, bit 31 if short.
- Z  out  1  result is all zeros over the active width.

## Operation
- States: IDLE, MULT, LO, HI, DONE. Encoding is free; it is not visible at ports.
- IDLE: START=1 → MULT, latching LONG and ACC. START=0 → remain in IDLE.
- MULT: LD_MUL=1 and MUL_HiLo=0; then unconditionally → LO.
- LO: MUL_HiLo=0.
  - 33-bit sum = B_In + (ACC ? C_In : 0).
  - Sum[31:0] is registered into RES_LO; sum[32] is registered into the internal carry.
  - Next state is HI if long, else DONE.
- HI: MUL_HiLo=1. RES_HI ← B_In + (ACC ? C_In : 0) + carry, modulo 2^32. Then → DONE.
- DONE:
  - DONE=1 for one cycle. N and Z are valid.
  - START=1 → MULT, giving back-to-back operation with LONG/ACC re-latched. Otherwise → IDLE.
- N and Z are registered, computed from the final sum at the LO edge (short) or HI edge (long).
- Z over 64 bits uses the stored RES_LO and the new high sum.
- RES_LO, RES_HI, N and Z hold their values after DONE until the next result is written. A new START does not clear them early.
- RES_HI is written 0 at the LO edge of a short sequence.
- START asserted in MULT, LO or HI is ignored; it is neither queued nor does it disturb the sequence.
- Arithmetic is unsigned modulo 2^64. Signed vs unsigned multiply is resolved upstream in the product, so the accumulate is identical for both.
- RST_N low, including mid-sequence: immediate → IDLE. All outputs and the internal carry go to 0. There is no partial write.

## Timing
- LD_MUL, MUL_HiLo, BUSY and DONE are decoded from the state register (Moore); there is no combinational path from inputs.
- BUSY=1 in MULT, LO and HI; 0 in IDLE and DONE.
- START sampled high at edge E:
  - MULT occupies the cycle after E.
  - The LO sample occurs at E+2.
  - The HI sample occurs at E+3 (long only).
  - DONE is high in the cycle after E+2 (short) or E+3 (long).
- Latency from START to DONE: 3 cycles short, 4 cycles long. Throughput is one result per 3 or 4 cycles with back-to-back START in DONE.
- B_In and C_In must be stable at the LO and HI sampling edges. Upstream guarantees this via MUL_HiLo and its own C-bus drive.
- Reset values: LD_MUL=0, MUL_HiLo=0, BUSY=0, DONE=0, RES_LO=0, RES_HI=0, N=0, Z=0.

## Test plan
- Short MLA:
  - Stimulus: START, LONG=0, ACC=1. LO cycle: B_In=0x00000006, C_In=0xFFFFFFFA.
  - Response: LD_MUL is one cycle after START; DONE is 3 cycles after START. RES_LO=0, RES_HI=0, Z=1, N=0.
- Long accumulate with carry:
  - Stimulus: START, LONG=1, ACC=1. LO: B_In=0xFFFFFFFF, C_In=0x00000001. HI: B_In=0x00000001, C_In=0x7FFFFFFF.
  - Response: MUL_HiLo=1 only in HI. RES_LO=0, RES_HI=0x80000001, N=1, Z=0, DONE 4 cycles after START.
- ACC=0:
  - Stimulus: long sequence with C_In=0xDEADBEEF in both halves. LO: B_In=0x12345678. HI: B_In=0.
  - Response: RES_LO=0x12345678, RES_HI=0, N=0, Z=0.
- Back-to-back and ignored START:
  - Stimulus: START held high continuously, alternating LONG.
  - Response: DONE pulses every 3 or 4 cycles as appropriate. No extra LD_MUL pulses occur during MULT, LO or HI.
- Reset mid-op:
  - Stimulus: RST_N low asynchronously during HI of a long sequence.
  - Response: all outputs are 0 immediately, without waiting for a clock edge. Then, after RST_N is released, a new short START completes normally with correct results.
